// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch-stage branch recovery table.
package fetch_pkg;

   localparam int unsigned BRT_BID_W    = 4;
   localparam int unsigned BRT_IDX_W    = 3;
   localparam int unsigned BRT_NCOMMIT  = 2;
   localparam int unsigned BRT_OQ_DEPTH = 4;
   localparam int unsigned BRT_ADDR_W   = 32;

   typedef struct packed {
      logic                  valid;
      logic [BRT_BID_W-1:0]  tag;
      logic                  taken;
      logic [BRT_ADDR_W-1:0] target;
   } brt_entry_t;

   typedef struct packed {
      logic [BRT_BID_W-1:0]  bid;
      logic [BRT_ADDR_W-1:0] pc;
      logic [1:0]            oldpattern;
      logic                  taken;
      logic [BRT_ADDR_W-1:0] target;
      logic                  nomatch;
   } brt_override_t;

   // Pointer advance modulo an arbitrary (non power-of-2) depth; n <= depth.
   function automatic int unsigned wrap_add(input int unsigned p, input int unsigned n,
                                            input int unsigned depth);
      int unsigned s;
      s = p + n;
      return (s >= depth) ? (s - depth) : s;
   endfunction

endpackage

// File: rtl/fetch_brt_mc_if.sv
// Prediction record, commit lanes and override handshake of the branch recovery table.
interface fetch_brt_mc_if
   import fetch_pkg::*;
#(
   parameter int unsigned NCOMMIT = BRT_NCOMMIT,
   parameter int unsigned BID_W   = BRT_BID_W,
   parameter int unsigned ADDR_W  = BRT_ADDR_W
) ();

   logic                      bp_valid;
   logic [BID_W-1:0]          bp_bid;
   logic                      bp_taken;
   logic                      bp_hit;
   logic [ADDR_W-1:0]         bp_target;
   logic                      flush;

   logic [NCOMMIT-1:0]        bc_valid;
   logic [NCOMMIT*BID_W-1:0]  bc_bid;
   logic [NCOMMIT*ADDR_W-1:0] bc_pc;
   logic [NCOMMIT*2-1:0]      bc_oldpattern;
   logic [NCOMMIT-1:0]        bc_taken;
   logic [NCOMMIT*ADDR_W-1:0] bc_target;
   logic                      bc_ready;

   logic                      bco_valid;
   logic                      bco_ready;
   logic [BID_W-1:0]          bco_bid;
   logic [ADDR_W-1:0]         bco_pc;
   logic [1:0]                bco_oldpattern;
   logic                      bco_taken;
   logic [ADDR_W-1:0]         bco_target;
   logic                      bco_nomatch;

   modport slave (
      input  bp_valid, bp_bid, bp_taken, bp_hit, bp_target, flush,
      input  bc_valid, bc_bid, bc_pc, bc_oldpattern, bc_taken, bc_target,
      output bc_ready,
      output bco_valid, bco_bid, bco_pc, bco_oldpattern, bco_taken, bco_target, bco_nomatch,
      input  bco_ready
   );

   modport master (
      output bp_valid, bp_bid, bp_taken, bp_hit, bp_target, flush,
      output bc_valid, bc_bid, bc_pc, bc_oldpattern, bc_taken, bc_target,
      input  bc_ready,
      input  bco_valid, bco_bid, bco_pc, bco_oldpattern, bco_taken, bco_target, bco_nomatch,
      output bco_ready
   );

endinterface

// File: rtl/fetch_brt_oq.sv
// Override queue: up to NCOMMIT in-order writes per cycle, one read, registered head.
module fetch_brt_oq
   import fetch_pkg::*;
#(
   parameter int unsigned NCOMMIT = BRT_NCOMMIT,
   parameter int unsigned DEPTH   = BRT_OQ_DEPTH
) (
   input  logic                              clk,
   input  logic                              resetn,
   input  logic          [NCOMMIT-1:0]       wr_valid_i,
   input  brt_override_t [NCOMMIT-1:0]       wr_data_i,
   input  logic                              rd_ready_i,
   output logic                              rd_valid_o,
   output brt_override_t                     rd_data_o,
   output logic [$clog2(DEPTH+1)-1:0]        count_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   brt_override_t     mem_q [DEPTH];
   brt_override_t     mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              head_valid_q, head_valid_d;
   brt_override_t     head_q, head_d;
   logic              deq;
   int unsigned       n_enq;

   // Lanes are compacted into consecutive slots, lane 0 first; the head is
   // re-read from the post-update storage so a write into an empty queue shows next cycle.
   always_comb begin
      mem_d = mem_q;
      n_enq = 0;
      for (int i = 0; i < NCOMMIT; i++) begin
         if (wr_valid_i[i]) begin
            mem_d[PTR_W'(wrap_add(32'(wr_ptr_q), n_enq, DEPTH))] = wr_data_i[i];
            n_enq = n_enq + 1;
         end
      end
      deq          = head_valid_q & rd_ready_i;
      wr_ptr_d     = PTR_W'(wrap_add(32'(wr_ptr_q), n_enq, DEPTH));
      rd_ptr_d     = deq ? PTR_W'(wrap_add(32'(rd_ptr_q), 1, DEPTH)) : rd_ptr_q;
      count_d      = count_q + CNT_W'(n_enq) - CNT_W'(deq);
      head_valid_d = (count_d != '0);
      head_d       = head_valid_d ? mem_d[rd_ptr_d] : head_q;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         head_valid_q <= 1'b0;
         head_q       <= '0;
      end else begin
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         head_valid_q <= head_valid_d;
         head_q       <= head_d;
      end
   end

   assign rd_valid_o = head_valid_q;
   assign rd_data_o  = head_q;
   assign count_o    = count_q;

endmodule

// File: rtl/fetch_brt_mc.sv
// Multi-commit branch recovery table: records fetch predictions, checks commit
// resolutions against them and queues mispredict overrides.
module fetch_brt_mc
   import fetch_pkg::*;
#(
   parameter int unsigned BID_W    = BRT_BID_W,
   parameter int unsigned IDX_W    = BRT_IDX_W,
   parameter int unsigned NCOMMIT  = BRT_NCOMMIT,
   parameter int unsigned OQ_DEPTH = BRT_OQ_DEPTH,
   parameter int unsigned ADDR_W   = BRT_ADDR_W
) (
   input  logic          clk,
   input  logic          resetn,
   fetch_brt_mc_if.slave bus
);

   localparam int unsigned DEPTH = 1 << IDX_W;
   localparam int unsigned CNT_W = $clog2(OQ_DEPTH + 1);

   brt_entry_t                  tbl_q [DEPTH];
   brt_entry_t                  r_q;
   logic [IDX_W-1:0]            lane_idx [NCOMMIT];
   logic [NCOMMIT-1:0]          acc;
   logic [NCOMMIT-1:0]          ovr_valid;
   brt_override_t [NCOMMIT-1:0] ovr_data;
   logic                        ready;
   logic [CNT_W-1:0]            oq_count;
   logic                        oq_valid;
   brt_override_t               oq_head;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_q <= '0;
      end else begin
         r_q <= '{valid:  bus.bp_valid,
                  tag:    bus.bp_bid,
                  taken:  bus.bp_taken & bus.bp_hit,
                  target: bus.bp_target};
      end
   end

   assign ready = (32'(OQ_DEPTH) - 32'(oq_count)) >= 32'(NCOMMIT);
   assign acc   = bus.bc_valid & {NCOMMIT{ready}};

   for (genvar g = 0; g < NCOMMIT; g++) begin : g_lane
      logic [BID_W-1:0]  lane_bid;
      logic [ADDR_W-1:0] lane_target;
      brt_entry_t        ent;
      logic              hit, pred_taken, mismatch;

      assign lane_bid    = bus.bc_bid[g*BID_W +: BID_W];
      assign lane_target = bus.bc_target[g*ADDR_W +: ADDR_W];
      assign lane_idx[g] = lane_bid[IDX_W-1:0];
      // The in-flight record is younger than the array copy at the same index.
      assign ent         = (r_q.valid && (r_q.tag[IDX_W-1:0] == lane_idx[g])) ? r_q
                                                                               : tbl_q[lane_idx[g]];
      assign hit         = ent.valid && (ent.tag == lane_bid);
      assign pred_taken  = hit && ent.taken;
      assign mismatch    = (bus.bc_taken[g] != pred_taken) |
                           (bus.bc_taken[g] & (lane_target != ent.target));
      assign ovr_valid[g] = acc[g] & mismatch;
      assign ovr_data[g]  = '{bid:        lane_bid,
                              pc:         bus.bc_pc[g*ADDR_W +: ADDR_W],
                              oldpattern: bus.bc_oldpattern[g*2 +: 2],
                              taken:      bus.bc_taken[g],
                              target:     lane_target,
                              nomatch:    ~hit};
   end

   // Flush and consume clear valid bits; the record write is issued last so it wins.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int k = 0; k < DEPTH; k++) tbl_q[k] <= '0;
      end else begin
         if (bus.flush) begin
            for (int k = 0; k < DEPTH; k++) tbl_q[k].valid <= 1'b0;
         end
         for (int i = 0; i < NCOMMIT; i++) begin
            if (acc[i]) tbl_q[lane_idx[i]].valid <= 1'b0;
         end
         if (r_q.valid) tbl_q[r_q.tag[IDX_W-1:0]] <= r_q;
      end
   end

   fetch_brt_oq #(
      .NCOMMIT (NCOMMIT),
      .DEPTH   (OQ_DEPTH)
   ) u_oq (
      .clk        (clk),
      .resetn     (resetn),
      .wr_valid_i (ovr_valid),
      .wr_data_i  (ovr_data),
      .rd_ready_i (bus.bco_ready),
      .rd_valid_o (oq_valid),
      .rd_data_o  (oq_head),
      .count_o    (oq_count)
   );

   assign bus.bc_ready       = ready;
   assign bus.bco_valid      = oq_valid;
   assign bus.bco_bid        = oq_head.bid;
   assign bus.bco_pc         = oq_head.pc;
   assign bus.bco_oldpattern = oq_head.oldpattern;
   assign bus.bco_taken      = oq_head.taken;
   assign bus.bco_target     = oq_head.target;
   assign bus.bco_nomatch    = oq_head.nomatch;

endmodule

// File: tb/tb_fetch_brt_mc.sv
// Scoreboard bench for fetch_brt_mc: expected overrides are queued at commit
// time and compared in order as the DUT hands them out.
module tb_fetch_brt_mc;
   import fetch_pkg::*;

   logic clk = 1'b0;
   logic resetn;

   always #5 clk = ~clk;

   fetch_brt_mc_if #(.NCOMMIT(2), .BID_W(4), .ADDR_W(32)) bus ();

   fetch_brt_mc #(
      .BID_W(4), .IDX_W(3), .NCOMMIT(2), .OQ_DEPTH(4), .ADDR_W(32)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   typedef struct {
      logic        v;
      logic [3:0]  bid;
      logic [31:0] pc;
      logic [1:0]  op;
      logic        t;
      logic [31:0] tg;
   } lane_t;

   int checks = 0;
   int errors = 0;
   brt_override_t exp_q[$];

   function automatic lane_t mk(input logic v, input logic [3:0] bid, input logic [31:0] pc,
                                input logic [1:0] op, input logic t, input logic [31:0] tg);
      lane_t l;
      l.v = v; l.bid = bid; l.pc = pc; l.op = op; l.t = t; l.tg = tg;
      return l;
   endfunction

   function automatic brt_override_t exp_of(input lane_t l, input logic nm);
      return '{bid: l.bid, pc: l.pc, oldpattern: l.op, taken: l.t, target: l.tg, nomatch: nm};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic record(input logic [3:0] bid, input logic t, input logic h, input logic [31:0] tg);
      bus.bp_valid = 1'b1; bus.bp_bid = bid; bus.bp_taken = t; bus.bp_hit = h; bus.bp_target = tg;
      step();
      bus.bp_valid = 1'b0;
   endtask

   task automatic drive_lanes(input lane_t l0, input lane_t l1);
      bus.bc_valid      = {l1.v, l0.v};
      bus.bc_bid        = {l1.bid, l0.bid};
      bus.bc_pc         = {l1.pc, l0.pc};
      bus.bc_oldpattern = {l1.op, l0.op};
      bus.bc_taken      = {l1.t, l0.t};
      bus.bc_target     = {l1.tg, l0.tg};
   endtask

   // One commit cycle, issued once the table is accepting lanes.
   task automatic commit(input lane_t l0, input lane_t l1);
      int n = 0;
      while (bus.bc_ready !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      checks++;
      if (bus.bc_ready !== 1'b1) begin
         errors++;
         $display("FAIL commit_ready_timeout: bc_ready=%b required 1", bus.bc_ready);
      end
      drive_lanes(l0, l1);
      step();
      bus.bc_valid = '0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || bus.bco_valid !== 1'b0) && n < 100) begin
         step();
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || bus.bco_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_drain: pending=%0d bco_valid=%b required 0/0", name, exp_q.size(), bus.bco_valid);
      end
   endtask

   // Output monitor: each accepted head must be the oldest expected override.
   always @(negedge clk) begin
      if (resetn === 1'b1 && bus.bco_valid === 1'b1 && bus.bco_ready === 1'b1) begin
         brt_override_t got;
         got = '{bid: bus.bco_bid, pc: bus.bco_pc, oldpattern: bus.bco_oldpattern,
                 taken: bus.bco_taken, target: bus.bco_target, nomatch: bus.bco_nomatch};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_override: got %h required none", got);
         end else begin
            brt_override_t e;
            e = exp_q.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL override_payload: got %h required %h", got, e);
            end
         end
      end
   end

   task automatic test_reset();
      checks++;
      if (bus.bco_valid !== 1'b0) begin errors++; $display("FAIL reset_bco_valid: got %b required 0", bus.bco_valid); end
      checks++;
      if (bus.bc_ready !== 1'b1) begin errors++; $display("FAIL reset_bc_ready: got %b required 1", bus.bc_ready); end
      checks++;
      if ({bus.bco_bid, bus.bco_pc, bus.bco_oldpattern, bus.bco_taken, bus.bco_target, bus.bco_nomatch} !== '0) begin
         errors++;
         $display("FAIL reset_payload: bid=%h pc=%h target=%h required 0", bus.bco_bid, bus.bco_pc, bus.bco_target);
      end
   endtask

   task automatic test_basic();
      lane_t idle = mk(0, 0, 0, 0, 0, 0);
      // Correct prediction consumes the entry; a repeat then misses.
      record(4'd3, 1'b1, 1'b1, 32'h1000);
      step();
      commit(mk(1, 3, 32'h0000_0300, 2'b10, 1, 32'h1000), idle);
      exp_q.push_back(exp_of(mk(1, 3, 32'h0000_0304, 2'b01, 1, 32'h1000), 1'b1));
      commit(mk(1, 3, 32'h0000_0304, 2'b01, 1, 32'h1000), idle);
      drain("basic_consume");
      // Target mismatch with a hit, visible one cycle after the commit.
      record(4'd3, 1'b1, 1'b1, 32'h1000);
      step();
      exp_q.push_back(exp_of(mk(1, 3, 32'h0000_0308, 2'b11, 1, 32'h2000), 1'b0));
      commit(mk(1, 3, 32'h0000_0308, 2'b11, 1, 32'h2000), idle);
      checks++;
      if (bus.bco_valid !== 1'b1 || bus.bco_target !== 32'h2000) begin
         errors++;
         $display("FAIL basic_latency: bco_valid=%b target=%h required 1/00002000", bus.bco_valid, bus.bco_target);
      end
      // Not-taken against a now-invalid entry is not an override.
      commit(mk(1, 3, 32'h0000_030c, 2'b00, 0, 32'h0), idle);
      drain("basic_mismatch");
   endtask

   task automatic test_forward();
      lane_t idle = mk(0, 0, 0, 0, 0, 0);
      record(4'd2, 1'b1, 1'b1, 32'h3000);
      commit(mk(1, 2, 32'h0000_0200, 2'b10, 1, 32'h3000), idle);
      exp_q.push_back(exp_of(mk(1, 10, 32'h0000_0a00, 2'b01, 1, 32'h3000), 1'b1));
      commit(mk(1, 10, 32'h0000_0a00, 2'b01, 1, 32'h3000), idle);
      drain("forward");
   endtask

   task automatic test_lookup();
      lane_t idle = mk(0, 0, 0, 0, 0, 0);
      // Two lanes on the same entry look up independently.
      record(4'd6, 1'b1, 1'b1, 32'h60);
      step();
      exp_q.push_back(exp_of(mk(1, 6, 32'h0000_0604, 2'b11, 1, 32'h61), 1'b0));
      commit(mk(1, 6, 32'h0000_0600, 2'b11, 1, 32'h60), mk(1, 6, 32'h0000_0604, 2'b11, 1, 32'h61));
      // Predicted taken, resolved not-taken.
      record(4'd7, 1'b1, 1'b1, 32'h70);
      step();
      exp_q.push_back(exp_of(mk(1, 7, 32'h0000_0700, 2'b10, 0, 32'h99), 1'b0));
      commit(mk(1, 7, 32'h0000_0700, 2'b10, 0, 32'h99), idle);
      // Predictor miss records not-taken, so a not-taken resolution agrees.
      record(4'd0, 1'b1, 1'b0, 32'h80);
      step();
      commit(mk(1, 0, 32'h0000_0000, 2'b01, 0, 32'h80), idle);
      drain("lookup");
   endtask

   task automatic test_backpressure();
      lane_t idle = mk(0, 0, 0, 0, 0, 0);
      bus.bco_ready = 1'b0;
      exp_q.push_back(exp_of(mk(1, 8, 32'h800, 2'b00, 1, 32'h8800), 1'b1));
      exp_q.push_back(exp_of(mk(1, 9, 32'h900, 2'b01, 1, 32'h9900), 1'b1));
      commit(mk(1, 8, 32'h800, 2'b00, 1, 32'h8800), mk(1, 9, 32'h900, 2'b01, 1, 32'h9900));
      checks++;
      if (bus.bc_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_cnt2: got %b required 1", bus.bc_ready); end
      exp_q.push_back(exp_of(mk(1, 11, 32'hb00, 2'b10, 1, 32'hbb00), 1'b1));
      commit(mk(1, 11, 32'hb00, 2'b10, 1, 32'hbb00), idle);
      checks++;
      if (bus.bc_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_cnt3: got %b required 0", bus.bc_ready); end
      // Lanes presented while not ready must be dropped.
      drive_lanes(mk(1, 12, 32'hc00, 2'b00, 1, 32'hcc00), mk(1, 13, 32'hd00, 2'b00, 1, 32'hdd00));
      step();
      bus.bc_valid = '0;
      step();
      checks++;
      if (bus.bco_valid !== 1'b1 || bus.bco_bid !== 4'd8 || bus.bco_target !== 32'h8800) begin
         errors++;
         $display("FAIL bp_hold: valid=%b bid=%h target=%h required 1/8/00008800", bus.bco_valid, bus.bco_bid, bus.bco_target);
      end
      bus.bco_ready = 1'b1;
      drain("backpressure");
      checks++;
      if (bus.bc_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b required 1", bus.bc_ready); end
   endtask

   task automatic test_back_to_back();
      lane_t a, b;
      for (int k = 0; k < 4; k++) begin
         a = mk(1, 4'(8 + 2 * k), 32'(32'h1000 + 16 * k), 2'(k), 1, 32'(32'h5000 + k));
         b = mk(1, 4'(9 + 2 * k), 32'(32'h2000 + 16 * k), 2'(k + 1), 1, 32'(32'h6000 + k));
         exp_q.push_back(exp_of(a, 1'b1));
         exp_q.push_back(exp_of(b, 1'b1));
         commit(a, b);
      end
      drain("back_to_back");
   endtask

   task automatic test_flush_reset();
      lane_t idle = mk(0, 0, 0, 0, 0, 0);
      record(4'd5, 1'b1, 1'b1, 32'h500);
      step();
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      exp_q.push_back(exp_of(mk(1, 5, 32'h0000_0500, 2'b10, 1, 32'h500), 1'b1));
      commit(mk(1, 5, 32'h0000_0500, 2'b10, 1, 32'h500), idle);
      // A record landing with the flush survives it.
      record(4'd4, 1'b1, 1'b1, 32'h400);
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      commit(mk(1, 4, 32'h0000_0400, 2'b11, 1, 32'h400), idle);
      drain("flush");
      // Reset mid-drain drops queue and table.
      record(4'd1, 1'b1, 1'b1, 32'h100);
      step();
      bus.bco_ready = 1'b0;
      commit(mk(1, 12, 32'hc0, 2'b00, 1, 32'h1), mk(1, 13, 32'hd0, 2'b01, 1, 32'h2));
      checks++;
      if (bus.bco_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b required 1", bus.bco_valid); end
      #2 resetn = 1'b0;
      #1;
      checks++;
      if (bus.bco_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b required 0", bus.bco_valid); end
      checks++;
      if (bus.bc_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready: got %b required 1", bus.bc_ready); end
      exp_q.delete();
      step();
      step();
      resetn = 1'b1;
      bus.bco_ready = 1'b1;
      step();
      exp_q.push_back(exp_of(mk(1, 1, 32'h0000_0100, 2'b01, 1, 32'h100), 1'b1));
      commit(mk(1, 1, 32'h0000_0100, 2'b01, 1, 32'h100), idle);
      drain("reset_table");
   endtask

   initial begin
      resetn            = 1'b0;
      bus.bp_valid      = 1'b0;
      bus.bp_bid        = '0;
      bus.bp_taken      = 1'b0;
      bus.bp_hit        = 1'b0;
      bus.bp_target     = '0;
      bus.flush         = 1'b0;
      bus.bc_valid      = '0;
      bus.bc_bid        = '0;
      bus.bc_pc         = '0;
      bus.bc_oldpattern = '0;
      bus.bc_taken      = '0;
      bus.bc_target     = '0;
      bus.bco_ready     = 1'b1;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      step();
      test_reset();
      test_basic();
      test_forward();
      test_lookup();
      test_backpressure();
      test_back_to_back();
      test_flush_reset();
      repeat (3) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_brt_mc.md
Name: fetch_brt_mc

Overview:
Parametrised, multi-commit Branch Recovery Table for the fetch stage.
- Records the fetch predictor's outcome (taken & hit, target) per branch ID, tagged with the full BID and a valid bit.
- Compares up to NCOMMIT commit-stage branch resolutions per cycle against the recorded outcomes.
- Buffers mispredict overrides in an output queue with a valid/ready handshake towards the predictor-update and redirect logic.

Parameters:
BID_W, 4, branch ID width; full BID is stored as tag.
IDX_W, 3, table index width; depth = 2^IDX_W, indexed by bid[IDX_W-1:0]; IDX_W <= BID_W.
NCOMMIT, 2, commit lanes per cycle; 1..4.
OQ_DEPTH, 4, override queue entries; OQ_DEPTH >= NCOMMIT.
ADDR_W, 32, PC/target width.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
bp_valid  in  1  prediction record valid
bp_bid  in  BID_W  prediction branch ID
bp_taken  in  1  predicted taken
bp_hit  in  1  predictor hit
bp_target  in  ADDR_W  predicted target
flush  in  1  invalidate all table entries
bc_valid  in  NCOMMIT  per-lane commit valid
bc_bid  in  NCOMMIT*BID_W  per-lane branch ID, lane 0 in LSBs
bc_pc  in  NCOMMIT*ADDR_W  per-lane branch PC
bc_oldpattern  in  NCOMMIT*2  per-lane old 2-bit counter
bc_taken  in  NCOMMIT  per-lane resolved taken
bc_target  in  NCOMMIT*ADDR_W  per-lane resolved target
bc_ready  out  1  lanes accepted this cycle
bco_valid  out  1  override head valid
bco_ready  in  1  consumer accepts head
bco_bid  out  BID_W  override branch ID
bco_pc  out  ADDR_W  override PC
bco_oldpattern  out  2  override old pattern
bco_taken  out  1  resolved taken
bco_target  out  ADDR_W  resolved target
bco_nomatch  out  1  override caused by invalid entry or tag miss

Behaviour:
- Reset (async assert, sync deassert by the existing reset tree):
  - All entry valid bits = 0; bp input register valid = 0; queue count = 0.
  - bco_valid = 0; all bco_* payloads = 0; bc_ready = 1.
- Prediction path:
  - bp_* is registered once (stage R).
  - At the next edge after R valid, entry[bid[IDX_W-1:0]] is written: tag = bid, taken = bp_taken & bp_hit, target, valid = 1.
- Lookup for each lane i with bc_valid[i] & bc_ready:
  - pred_taken = entry.valid & (tag == bc_bid) & entry.taken.
  - Forwarding: if R is valid and its index matches, R's data is used instead of the array contents.
  - nomatch = ~(forwarded or entry valid with tag match).
  - mismatch = (bc_taken != pred_taken) | (bc_taken & (bc_target != pred_target)).
  - A non-taken branch with a tag miss is not an override.
- Consume: every accepted lane clears valid of its entry at the edge, unless R writes the same index that cycle (the write wins). Two lanes hitting the same index each look up independently.
- Flush: all valid bits clear at the edge. A same-cycle R write still lands (it is younger). Queued overrides are not affected.
- bc_ready = (OQ_DEPTH - count) >= NCOMMIT, from registered count.
  - With bc_ready = 0, lanes are ignored: no lookup, no clear, no enqueue. Upstream holds.
- Override queue:
  - Overrides from lanes accepted in cycle t enqueue in lane order, lane 0 oldest.
  - Head is visible on bco_* at t+1 when the queue was empty (1-cycle latency, registered outputs).
  - Dequeue on bco_valid & bco_ready. Enqueue and dequeue in the same cycle are allowed.
  - count is updated by enqueued minus dequeued. Pointers wrap modulo OQ_DEPTH; non-power-of-2 depths are supported.
  - bco_* payloads hold stable while bco_valid & ~bco_ready.
- Reset mid-operation: queued overrides and table contents are discarded immediately.

Decomposition:
- Package fetch_pkg:
  - brt_entry_t (valid, tag, taken, target).
  - brt_override_t (bid, pc, oldpattern, taken, target, nomatch).
  - BRT default parameter constants.
- Sub-module fetch_brt_oq: NCOMMIT-write, single-read FIFO of brt_override_t, with count output and registered head.

Test Plan:
1. Record bid=3, taken=1, hit=1, target=0x1000; two cycles later commit lane0 bid=3, taken=1, target=0x1000 -> no override; entry 3 invalid afterwards.
2. Same record, commit target=0x2000 -> one cycle later bco_valid=1, bid=3, target=0x2000, nomatch=0.
3. Record bid=2 in cycle t; commit bid=2 (taken=1, target match) in cycle t+1 -> forwarding gives no override. Commit bid=10 (same index 2, tag miss), taken=1 -> override with nomatch=1.
4. Hold bco_ready=0 and send mismatching pairs on both lanes -> queue fills; bc_ready=0 when count=3 with OQ_DEPTH=4, NCOMMIT=2. Release -> overrides drain in order lane0, lane1, next cycle's lane0, ...
5. Record bid=5, assert flush, then commit bid=5 taken=1 -> override nomatch=1. Assert resetn=0 mid-drain -> bco_valid=0 immediately, bc_ready=1.
